// File: rtl/spin_controller.sv
// Three-reel spin sequencer: spins reels from the LFSR value, stops them at staggered
// counts, then reports whether two or three reels show the same symbol.
module spin_controller #(
  parameter int unsigned SPIN_CYCLES = 16,
  parameter int unsigned STAGGER     = 8,
  parameter int unsigned SYMBOLS     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] rand_in,
  output logic       busy,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic [2:0] reel_stop,
  output logic       done,
  output logic [1:0] result,
  output logic [7:0] spin_count
);

  typedef enum logic [1:0] {StIdle, StSpin, StDone} state_e;

  localparam logic [7:0] Stop0   = 8'(SPIN_CYCLES - 1);
  localparam logic [7:0] Stop1   = 8'(SPIN_CYCLES - 1 + STAGGER);
  localparam logic [7:0] Stop2   = 8'(SPIN_CYCLES - 1 + 2 * STAGGER);
  // Compared 5 bits wide so that SYMBOLS = 16 never triggers the subtract.
  localparam logic [4:0] SymWide = 5'(SYMBOLS);
  localparam logic [3:0] SymLow  = SymWide[3:0];

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] stopped_q;
  logic [3:0] sym;
  logic [2:0] hit;
  logic [1:0] match;

  always_comb begin
    sym = ({1'b0, rand_in} >= SymWide) ? (rand_in - SymLow) : rand_in;
    hit = {(cnt_q == Stop2), (cnt_q == Stop1), (cnt_q == Stop0)};
    // reel2 is still loading on the final edge, so its incoming symbol is used.
    if ((reel0 == reel1) && (reel1 == sym)) begin
      match = 2'b10;
    end else if ((reel0 == reel1) || (reel0 == sym) || (reel1 == sym)) begin
      match = 2'b01;
    end else begin
      match = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      stopped_q  <= '0;
      busy       <= 1'b0;
      reel0      <= '0;
      reel1      <= '0;
      reel2      <= '0;
      reel_stop  <= '0;
      done       <= 1'b0;
      result     <= '0;
      spin_count <= '0;
    end else begin
      reel_stop <= '0;
      done      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StSpin;
            cnt_q     <= '0;
            stopped_q <= '0;
            busy      <= 1'b1;
          end
        end
        StSpin: begin
          cnt_q <= cnt_q + 8'd1;
          if (!stopped_q[0]) reel0 <= sym;
          if (!stopped_q[1]) reel1 <= sym;
          if (!stopped_q[2]) reel2 <= sym;
          stopped_q <= stopped_q | hit;
          reel_stop <= hit;
          if (hit[2]) begin
            state_q <= StDone;
            done    <= 1'b1;
            result  <= match;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          busy       <= 1'b0;
          spin_count <= spin_count + 8'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spin_controller.sv
// Directed bench for spin_controller with default parameters; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_spin_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] rand_in = 4'd0;
  logic       busy;
  logic [3:0] reel0;
  logic [3:0] reel1;
  logic [3:0] reel2;
  logic [2:0] reel_stop;
  logic       done;
  logic [1:0] result;
  logic [7:0] spin_count;

  int checks = 0;
  int failures = 0;

  spin_controller dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rand_in   (rand_in),
    .busy      (busy),
    .reel0     (reel0),
    .reel1     (reel1),
    .reel2     (reel2),
    .reel_stop (reel_stop),
    .done      (done),
    .result    (result),
    .spin_count(spin_count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_stop(input int n);
    return (n == 16) ? 3'b001 : (n == 24) ? 3'b010 : (n == 32) ? 3'b100 : 3'b000;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    rand_in = 4'd5;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, reel0, reel1, reel2, reel_stop, done, result, spin_count} !== 27'd0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got=%h exp=0", i,
                 {busy, reel0, reel1, reel2, reel_stop, done, result, spin_count});
      end
    end
  endtask

  task automatic test_reset_mid_spin;
    rand_in = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy_rise got=%b exp=1", busy);
    end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, reel0, reel1, reel2, reel_stop, done, result, spin_count} !== 27'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0",
               {busy, reel0, reel1, reel2, reel_stop, done, result, spin_count});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_stays_idle got=%b exp=0", busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      checks++;
      if ({reel_stop, done, busy} !== {exp_stop(n), (n == 32), (n <= 32)}) begin
        failures++;
        $display("FAIL mid_respin_timing cycle=%0d got=%b exp=%b", n,
                 {reel_stop, done, busy}, {exp_stop(n), (n == 32), (n <= 32)});
      end
    end
    checks++;
    if ({reel0, reel1, reel2, result, spin_count} !== {12'h999, 2'b10, 8'd1}) begin
      failures++;
      $display("FAIL mid_respin_final got=%h exp=%h",
               {reel0, reel1, reel2, result, spin_count}, {12'h999, 2'b10, 8'd1});
    end
  endtask

  task automatic test_same_symbol;
    int dones = 0;
    rand_in = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      checks++;
      if ({reel_stop, done, busy} !== {exp_stop(n), (n == 32), (n <= 32)}) begin
        failures++;
        $display("FAIL same_timing cycle=%0d got=%b exp=%b", n,
                 {reel_stop, done, busy}, {exp_stop(n), (n == 32), (n <= 32)});
      end
    end
    checks++;
    if ({reel0, reel1, reel2, result, spin_count} !== {12'h555, 2'b10, 8'd2}) begin
      failures++;
      $display("FAIL same_final got=%h exp=%h",
               {reel0, reel1, reel2, result, spin_count}, {12'h555, 2'b10, 8'd2});
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL same_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_no_match;
    rand_in = 4'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (n <= 16) begin
        checks++;
        if ({reel1, reel2} !== 8'h22) begin
          failures++;
          $display("FAIL nomatch_live_track cycle=%0d got=%h exp=22", n, {reel1, reel2});
        end
      end
      if (n == 16) rand_in = 4'd3;
      if (n == 24) rand_in = 4'd15;
    end
    checks++;
    if ({reel0, reel1, reel2, result, spin_count} !== {12'h235, 2'b00, 8'd3}) begin
      failures++;
      $display("FAIL nomatch_final got=%h exp=%h",
               {reel0, reel1, reel2, result, spin_count}, {12'h235, 2'b00, 8'd3});
    end
  endtask

  task automatic test_pair_match;
    int dones = 0;
    rand_in = 4'd7;
    start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      checks++;
      if ({reel_stop, busy} !== {exp_stop(n), (n <= 32)}) begin
        failures++;
        $display("FAIL pair_no_restart cycle=%0d got=%b exp=%b", n,
                 {reel_stop, busy}, {exp_stop(n), (n <= 32)});
      end
      if (n == 24) rand_in = 4'd1;
      if (n == 33) start = 1'b0;
    end
    checks++;
    if ({reel0, reel1, reel2, result, spin_count} !== {12'h771, 2'b01, 8'd4}) begin
      failures++;
      $display("FAIL pair_final got=%h exp=%h",
               {reel0, reel1, reel2, result, spin_count}, {12'h771, 2'b01, 8'd4});
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL pair_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_cnt = 8'd4;
    logic       wrapped = 1'b0;
    for (int s = 0; s < 256; s++) begin
      int w = 0;
      while (busy !== 1'b0 && w < 50) begin
        @(negedge clk);
        w++;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (done !== 1'b1 && w < 60) begin
        rand_in = 4'(s * 3 + w);
        @(negedge clk);
        w++;
      end
      checks++;
      if (done !== 1'b1) begin
        failures++;
        $display("FAIL b2b_done_timeout spin=%0d got=%b exp=1", s, done);
      end else if (result === 2'b11) begin
        failures++;
        $display("FAIL b2b_result spin=%0d got=%b exp=not 11", s, result);
      end
      @(negedge clk);
      exp_cnt = exp_cnt + 8'd1;
      if (spin_count === 8'd0) wrapped = 1'b1;
      checks++;
      if ({busy, spin_count} !== {1'b0, exp_cnt}) begin
        failures++;
        $display("FAIL b2b_count spin=%0d got=%h exp=%h", s, {busy, spin_count},
                 {1'b0, exp_cnt});
      end
    end
    checks++;
    if (wrapped !== 1'b1) begin
      failures++;
      $display("FAIL b2b_wrap got=%b exp=1", wrapped);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_spin();
    test_same_symbol();
    test_no_match();
    test_pair_match();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
